// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes,
// datapath mux selects and the bundled control-strobe struct.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_wait_timer.sv
// Memory-wait watchdog: counts unacknowledged cycles in a wait state and
// raises a sticky timeout when the count reaches WAIT_MAX without an ack.
module mem_wait_timer #(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic ack_i,
  output logic expire_o,
  output logic timeout_o
);

  localparam int unsigned CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_MAX);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic          expire;

  // Any exit from the wait state (ack, expiry, or not waiting) zeroes the
  // count, so the next wait state is always entered with a clean counter.
  always_comb begin
    expire    = active_i && !ack_i && (cnt_q == LIMIT);
    cnt_d     = '0;
    timeout_d = timeout_q | expire;
    if (active_i && !ack_i && !expire)
      cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign expire_o  = expire;
  assign timeout_o = timeout_q;

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the shared multi-cycle MIPS datapath (R, addi, lw,
// sw, beq, j) with a memory-acknowledge handshake and wait watchdog.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] Op_i,
  input  logic       MemAck_i,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       MemtoReg_o,
  output logic       RegDst_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] ALUOp_o,
  output logic [1:0] PCSource_o,
  output logic [3:0] State_o,
  output logic       Illegal_o,
  output logic       Timeout_o
);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       illegal_q, illegal_d;
  logic       wait_st, expire, timeout;
  ctrl_t      ctrl, ctrl_out;

  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .active_i (wait_st),
    .ack_i    (MemAck_i),
    .expire_o (expire),
    .timeout_o(timeout)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  if (MemAck_i) state_d = S_DECODE;
      S_DECODE: begin
        op_d = Op_i;
        case (Op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (MemAck_i)    state_d = S_MEMWB;
        else if (expire) state_d = S_FETCH;
      end
      S_MEMWR:  if (MemAck_i || expire) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = MemAck_i;
        ctrl.pc_write  = MemAck_i;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMMSH;
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      default:  ctrl = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      op_q      <= OP_R;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end

  // Gate strobes combinationally so a mid-instruction reset kills any
  // register/memory write in the same cycle rst_i rises.
  assign ctrl_out = rst_i ? '0 : ctrl;

  assign PCWrite_o     = ctrl_out.pc_write;
  assign PCWriteCond_o = ctrl_out.pc_write_cond;
  assign IorD_o        = ctrl_out.iord;
  assign MemRead_o     = ctrl_out.mem_read;
  assign MemWrite_o    = ctrl_out.mem_write;
  assign IRWrite_o     = ctrl_out.ir_write;
  assign MemtoReg_o    = ctrl_out.mem_to_reg;
  assign RegDst_o      = ctrl_out.reg_dst;
  assign RegWrite_o    = ctrl_out.reg_write;
  assign ALUSrcA_o     = ctrl_out.alu_src_a;
  assign ALUSrcB_o     = ctrl_out.alu_src_b;
  assign ALUOp_o       = ctrl_out.alu_op;
  assign PCSource_o    = ctrl_out.pc_source;
  assign State_o       = state_q;
  assign Illegal_o     = illegal_q;
  assign Timeout_o     = timeout;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore FSM that sequences the shared multi-cycle MIPS datapath (one ALU, one unified memory port) for R-type, addi, lw, sw, beq and j. Sits beside the datapath and takes the opcode from the instruction register. Drives per-state control strobes and waits on a memory-acknowledge handshake. A watchdog flags memory accesses that are never acknowledged.

Parameters:
WAIT_MAX, 255, max cycles spent in one memory-wait state before timeout (1..255)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
Op_i  in  6  opcode field IR[31:26]
MemAck_i  in  1  memory access completes this cycle
PCWrite_o  out  1  unconditional PC write
PCWriteCond_o  out  1  PC write qualified by ALU zero (datapath ANDs)
IorD_o  out  1  memory address: 0 = PC, 1 = ALUOut
MemRead_o  out  1  memory read request
MemWrite_o  out  1  memory write request
IRWrite_o  out  1  instruction register load
MemtoReg_o  out  1  register write data: 1 = MDR
RegDst_o  out  1  destination: 1 = rd, 0 = rt
RegWrite_o  out  1  register file write
ALUSrcA_o  out  1  0 = PC, 1 = reg A
ALUSrcB_o  out  2  00 = reg B, 01 = 4, 10 = signext imm, 11 = signext imm<<2
ALUOp_o  out  2  00 = add, 01 = sub, 10 = funct decode
PCSource_o  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
State_o  out  4  current state encoding (debug)
Illegal_o  out  1  one-cycle pulse: unsupported opcode decoded
Timeout_o  out  1  sticky: memory wait exceeded WAIT_MAX

Behaviour:
- Reset (rst_i high, asynchronous): state = FETCH (0), wait counter 0, Timeout_o 0, Illegal_o 0. All other outputs forced to 0 while rst_i is high. FETCH outputs appear in the first cycle after deassertion.
- Opcodes: R 000000, addi 001000, lw 100011, sw 101011, beq 000100, j 000010. All others are illegal.
- States and encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11.
  - 12..15 are unreachable and recover to FETCH.
- Outputs per state (any output not listed is 0):
  - FETCH: MemRead = 1, ALUSrcB = 01; IRWrite = PCWrite = MemAck_i (the only Mealy terms).
  - DECODE: ALUSrcB = 11.
  - MEMADR / ADDIEX: ALUSrcA = 1, ALUSrcB = 10.
  - MEMRD: MemRead = 1, IorD = 1.
  - MEMWB: RegWrite = 1, MemtoReg = 1.
  - MEMWR: MemWrite = 1, IorD = 1.
  - EXEC: ALUSrcA = 1, ALUOp = 10.
  - RWB: RegWrite = 1, RegDst = 1.
  - BRANCH: ALUSrcA = 1, ALUOp = 01, PCWriteCond = 1, PCSource = 01.
  - JUMP: PCWrite = 1, PCSource = 10.
  - ADDIWB: RegWrite = 1.
- Transitions:
  - FETCH -> DECODE on MemAck_i, otherwise stay.
  - DECODE: lw/sw -> MEMADR; R -> EXEC; beq -> BRANCH; j -> JUMP; addi -> ADDIEX; illegal -> FETCH with Illegal_o = 1 for the next cycle.
  - MEMADR -> MEMRD (lw) or MEMWR (sw).
  - MEMRD -> MEMWB on ack. MEMWR -> FETCH on ack.
  - EXEC -> RWB; ADDIEX -> ADDIWB.
  - MEMWB, RWB, BRANCH, JUMP, ADDIWB -> FETCH.
- Opcode sampling: Op_i is sampled only in DECODE and latched internally. Later states use the latched copy, so Op_i changes after DECODE have no effect.
- Zero-wait latency (cycles): R 4, addi 4, lw 5, sw 4, beq 3, j 3. Each cycle of ack delay adds one cycle to the affected wait state.
- Watchdog:
  - Counter clears on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle in that state without ack, saturating at WAIT_MAX.
  - If the counter equals WAIT_MAX and MemAck_i is low: Timeout_o sets (sticky until reset) and state goes to FETCH, abandoning the instruction.
  - MemAck_i high in the same cycle wins over timeout.
- MemAck_i outside wait states is ignored.
- Reset asserted mid-instruction aborts immediately; no partial register or memory write is issued after rst_i rises.

Decomposition:
- Shared package holds:
  - state encodings;
  - opcode constants;
  - ALUOp, ALUSrcB and PCSource encodings.
- One sub-module, mem_wait_timer (counter, saturate, timeout compare, parameterised by WAIT_MAX).

Test Plan:
1. Reset, then lw (100011) with MemAck_i high every cycle -> State_o 0,1,2,3,4,0; MemtoReg_o = RegWrite_o = 1 only in state 4; IRWrite_o = 1 in cycle 1.
2. R-type with fetch ack delayed 3 cycles -> FETCH held 4 cycles; IRWrite_o/PCWrite_o high only in the ack cycle; then 1,6,7,0 with RegDst_o = 1 in state 7.
3. beq then j -> BRANCH drives ALUOp_o = 01, PCWriteCond_o = 1, PCSource_o = 01; JUMP drives PCWrite_o = 1, PCSource_o = 10; each takes 3 cycles.
4. Opcode 111111 -> Illegal_o pulses exactly 1 cycle; state returns to 0; no RegWrite_o/MemWrite_o asserted.
5. WAIT_MAX = 4, sw with MemAck_i never high in MEMWR -> Timeout_o rises after 5 cycles in state 5, stays high; state returns to 0; ack in the limit cycle instead gives a normal completion with no timeout.
6. rst_i pulsed while in state 4 (MEMWB) -> RegWrite_o drops immediately; after release State_o = 0 and Timeout_o = 0.
